// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall/bubble, EX flush and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  MemReadD,
  input  logic                  ALUSrcD,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic                  JalrD,
  input  logic [1:0]            ResultSrcD,
  input  logic [2:0]            ALUControlD,
  input  logic [2:0]            Funct3D,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  EnE,
  input  logic                  FlushE,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  MemReadE,
  output logic                  ALUSrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  JalrE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic [2:0]            Funct3E,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  StallF,
  output logic                  StallD,
  output logic [CNT_W-1:0]      BubbleCnt
);
  localparam int CW = 15;
  localparam int DW = 5 * DATA_WIDTH + 3 * REG_ADDR_W;
  logic [CW-1:0] ctrl_in, ctrl_d, ctrl_q;
  logic [DW-1:0] data_in, data_d, data_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic valid_d, valid_q;
  logic use1, use2, load_use, bubble;
  assign ctrl_in = {RegWriteD, MemWriteD, MemReadD, ALUSrcD, BranchD, JumpD, JalrD,
                    ResultSrcD, ALUControlD, Funct3D};
  assign data_in = {RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};
  assign {RegWriteE, MemWriteE, MemReadE, ALUSrcE, BranchE, JumpE, JalrE,
          ResultSrcE, ALUControlE, Funct3E} = ctrl_q;
  assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = data_q;
  assign ValidE    = valid_q;
  assign BubbleCnt = cnt_q;
  // lui (PASS_B) ignores rs1; rs2 only matters for R-type ALU ops and stores
  assign use1     = ValidD & ~JumpD & (ALUControlD != 3'b010);
  assign use2     = ValidD & ~JumpD & (~ALUSrcD | MemWriteD);
  assign load_use = valid_q & MemReadE & (RdE != '0) &
                    ((use1 & (Rs1D == RdE)) | (use2 & (Rs2D == RdE)));
  assign StallF   = load_use & ~FlushE & EnE;
  assign StallD   = StallF;
  assign bubble   = FlushE | (EnE & load_use);
  always_comb begin
    valid_d = bubble ? 1'b0 : EnE ? ValidD : valid_q;
    ctrl_d  = bubble ? '0 : !EnE ? ctrl_q : ValidD ? ctrl_in : '0;
    data_d  = (FlushE | EnE) ? data_in : data_q;
    cnt_d   = (StallF & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage; counter width shrunk to 3 to reach saturation quickly.
module tb_id_ex_stage;
  logic clk = 1'b0, rst_n = 1'b1;
  logic ValidD, RegWriteD, MemWriteD, MemReadD, ALUSrcD, BranchD, JumpD, JalrD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD, Funct3D;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic EnE, FlushE;
  logic ValidE, RegWriteE, MemWriteE, MemReadE, ALUSrcE, BranchE, JumpE, JalrE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic StallF, StallD;
  logic [2:0] BubbleCnt;
  int checks = 0, errors = 0;
  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .MemReadD(MemReadD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD), .JalrD(JalrD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D), .RD1D(RD1D),
    .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .EnE(EnE), .FlushE(FlushE), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemReadE(MemReadE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
    .JumpE(JumpE), .JalrE(JalrE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .StallF(StallF),
    .StallD(StallD), .BubbleCnt(BubbleCnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_d(input logic v, rw, mw, mr, as, input logic [2:0] aluc, input logic j,
                       input logic [4:0] r1, r2, rd);
    ValidD = v; RegWriteD = rw; MemWriteD = mw; MemReadD = mr; ALUSrcD = as;
    ALUControlD = aluc; JumpD = j; Rs1D = r1; Rs2D = r2; RdD = rd;
    ResultSrcD = mr ? 2'b01 : 2'b00; Funct3D = mr ? 3'b100 : 3'b000;
    BranchD = 1'b0; JalrD = 1'b0;
  endtask
  initial begin
    set_d(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = 32'h100; PCPlus4D = 32'h104;
    EnE = 1'b1; FlushE = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", ValidE, 0);
    check("rst_regwrite", RegWriteE, 0);
    check("rst_cnt", BubbleCnt, 0);
    check("rst_stall", StallD, 0);
    @(negedge clk) rst_n = 1'b1;
    set_d(1, 1, 0, 0, 1, 3'b000, 0, 0, 0, 1); ImmExtD = 32'd5;
    @(negedge clk);
    check("addi_regwrite", RegWriteE, 1);
    check("addi_imm", ImmExtE, 5);
    check("addi_rd", RdE, 1);
    check("addi_valid", ValidE, 1);
    // load-use through rs1
    set_d(1, 1, 0, 1, 1, 3'b000, 0, 2, 0, 5);
    @(negedge clk);
    check("lbu_memread", MemReadE, 1);
    check("lbu_resultsrc", ResultSrcE, 2'b01);
    set_d(1, 1, 0, 0, 0, 3'b000, 0, 5, 1, 6);
    #1;
    check("lu_stalld", StallD, 1);
    check("lu_stallf", StallF, 1);
    @(negedge clk);
    check("lu_bub_valid", ValidE, 0);
    check("lu_bub_regwrite", RegWriteE, 0);
    check("lu_bub_memread", MemReadE, 0);
    check("lu_cnt1", BubbleCnt, 1);
    check("lu_stall_clear", StallD, 0);
    @(negedge clk);
    check("lu_add_rd", RdE, 6);
    check("lu_add_valid", ValidE, 1);
    check("lu_cnt_hold", BubbleCnt, 1);
    // load-use through rs2 of a store
    set_d(1, 1, 0, 1, 1, 3'b000, 0, 2, 0, 5);
    @(negedge clk);
    set_d(1, 0, 1, 0, 1, 3'b000, 0, 2, 5, 0);
    #1 check("sw_stall", StallD, 1);
    @(negedge clk);
    check("sw_bub_memwrite", MemWriteE, 0);
    check("sw_cnt2", BubbleCnt, 2);
    @(negedge clk);
    check("sw_memwrite", MemWriteE, 1);
    // loads into x0 never stall
    set_d(1, 1, 0, 1, 1, 3'b000, 0, 2, 0, 0);
    @(negedge clk);
    set_d(1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 6);
    #1 check("x0_nostall", StallD, 0);
    @(negedge clk);
    // lui/invalid/jump behind a load of x5
    set_d(1, 1, 0, 1, 1, 3'b000, 0, 2, 0, 5);
    @(negedge clk);
    set_d(1, 1, 0, 0, 1, 3'b010, 0, 5, 5, 5);
    #1 check("lui_nostall", StallD, 0);
    @(negedge clk);
    check("lui_valid", ValidE, 1);
    check("lui_aluctl", ALUControlE, 3'b010);
    check("lui_cnt", BubbleCnt, 2);
    set_d(1, 1, 0, 1, 1, 3'b000, 0, 2, 0, 5);
    @(negedge clk);
    set_d(0, 1, 0, 0, 0, 3'b000, 0, 5, 5, 6);
    #1 check("invalid_nostall", StallD, 0);
    set_d(1, 1, 0, 0, 0, 3'b000, 1, 5, 5, 1);
    #1 check("jump_nostall", StallD, 0);
    // flush beats load-use
    set_d(1, 1, 0, 0, 0, 3'b000, 0, 5, 1, 6); RD1D = 32'hDEADBEEF; FlushE = 1'b1;
    #1;
    check("flush_stalld", StallD, 0);
    check("flush_stallf", StallF, 0);
    @(negedge clk);
    check("flush_valid", ValidE, 0);
    check("flush_regwrite", RegWriteE, 0);
    check("flush_data", RD1E, 32'hDEADBEEF);
    check("flush_cnt", BubbleCnt, 2);
    FlushE = 1'b0;
    // hold with EnE=0
    set_d(1, 1, 0, 0, 0, 3'b000, 0, 1, 2, 9); ImmExtD = 32'h99;
    @(negedge clk);
    EnE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_d(i[0], 0, 1, 1, 1, 3'b001, 0, 9, 9, 5'(10 + i)); ImmExtD = i;
      @(negedge clk);
      check("hold_rd", RdE, 9);
      check("hold_imm", ImmExtE, 32'h99);
      check("hold_valid", ValidE, 1);
      check("hold_regwrite", RegWriteE, 1);
    end
    FlushE = 1'b1;
    @(negedge clk);
    check("hold_flush_valid", ValidE, 0);
    check("hold_flush_regwrite", RegWriteE, 0);
    FlushE = 1'b0; EnE = 1'b1;
    // lw x5,0(x5) back-to-back: a bubble every other cycle
    set_d(1, 1, 0, 1, 1, 3'b000, 0, 5, 0, 5);
    repeat (20) @(negedge clk);
    check("sat_cnt", BubbleCnt, 7);
    repeat (4) @(negedge clk);
    check("sat_nowrap", BubbleCnt, 7);
    // async reset mid-run
    set_d(1, 1, 0, 0, 0, 3'b000, 0, 1, 2, 6);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", ValidE, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ValidE, 0);
    check("mid_rst_regwrite", RegWriteE, 0);
    check("mid_rst_rd", RdE, 0);
    check("mid_rst_cnt", BubbleCnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
